// File: rtl/uart_tx_frame_if.sv
// Host-side handshake bundle for the UART transmit framer.
// UART_TX_BREAK_EN adds the break_req line-break request.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  baud_tick;
  logic                  send;
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            parity_type;
  logic                  tx;
  logic                  busy;
  logic                  done;
`ifdef UART_TX_BREAK_EN
  logic                  break_req;

  modport master (
    output baud_tick, send, data_in, parity_type, break_req,
    input  tx, busy, done
  );

  modport slave (
    input  baud_tick, send, data_in, parity_type, break_req,
    output tx, busy, done
  );
`else
  modport master (
    output baud_tick, send, data_in, parity_type,
    input  tx, busy, done
  );

  modport slave (
    input  baud_tick, send, data_in, parity_type,
    output tx, busy, done
  );
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, parity slot, STOP_BITS stops.
// Define UART_TX_BREAK_EN to add break_req (hold tx low while idle).
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic           clock,
  input logic           reset_n,
  uart_tx_frame_if.slave bus
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);
  localparam logic LastStop = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  stop_q, stop_d;
  logic                  brk;
  logic                  par_calc;

`ifdef UART_TX_BREAK_EN
  assign brk = bus.break_req;
`else
  assign brk = 1'b0;
`endif

  // Parity bit is resolved at accept so later parity_type changes cannot leak in.
  always_comb begin
    par_calc = 1'b1;
    case (bus.parity_type)
      2'b01:   par_calc = ~^bus.data_in;
      2'b10:   par_calc = ^bus.data_in;
      default: par_calc = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    case (state_q)
      StIdle: begin
        tx_d = ~brk;
        // baud_tick in the accept cycle is deliberately ignored: full-length start bit.
        if (bus.send && !brk) begin
          shift_d = bus.data_in;
          par_d   = par_calc;
          busy_d  = 1'b1;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (bus.baud_tick) begin
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bus.baud_tick) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bus.baud_tick) begin
          if (cnt_q == LastBit) begin
            tx_d    = par_q;
            state_d = StParity;
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            tx_d    = shift_d[0];
          end
        end
      end
      StParity: begin
        if (bus.baud_tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bus.baud_tick) begin
          if (stop_q == LastStop) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b1;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame; expected frames are hand-computed bit strings.
module tb_uart_tx_frame #(
  parameter int unsigned STOP_BITS = 1
);

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(
    .DATA_WIDTH(8),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns just after the clock edge that sampled the tick.
  task automatic tick();
    repeat (3) @(negedge clock);
    bus.baud_tick = 1'b1;
    @(negedge clock);
    bus.baud_tick = 1'b0;
  endtask

  task automatic accept(input logic [7:0] d, input logic [1:0] p, input bit with_tick);
    bus.send        = 1'b1;
    bus.data_in     = d;
    bus.parity_type = p;
    bus.baud_tick   = with_tick;
    @(negedge clock);
    bus.send        = 1'b0;
    bus.baud_tick   = 1'b0;
    bus.data_in     = ~d;
    bus.parity_type = ~p;
    check("accept_busy", {31'b0, bus.busy}, 32'd1);
    check("accept_tx",   {31'b0, bus.tx},   32'd1);
    check("accept_done", {31'b0, bus.done}, 32'd0);
  endtask

  // exp lists start, data LSB first, parity, first stop; exp[10] is sent first.
  task automatic run_frame(input string tag, input logic [10:0] exp, input int inject_at);
    for (int i = 0; i < 11; i++) begin
      tick();
      check($sformatf("%s_tx%0d", tag, i),   {31'b0, bus.tx},   {31'b0, exp[10-i]});
      check($sformatf("%s_busy%0d", tag, i), {31'b0, bus.busy}, 32'd1);
      check($sformatf("%s_done%0d", tag, i), {31'b0, bus.done}, 32'd0);
      if (i == inject_at) begin
        bus.send        = 1'b1;
        bus.data_in     = 8'hFF;
        bus.parity_type = 2'b01;
        @(negedge clock);
        bus.send        = 1'b0;
      end
    end
    for (int s = 1; s < int'(STOP_BITS); s++) begin
      tick();
      check($sformatf("%s_xstop_tx", tag),   {31'b0, bus.tx},   32'd1);
      check($sformatf("%s_xstop_done", tag), {31'b0, bus.done}, 32'd0);
    end
    tick();
    check($sformatf("%s_end_done", tag), {31'b0, bus.done}, 32'd1);
    check($sformatf("%s_end_busy", tag), {31'b0, bus.busy}, 32'd0);
    check($sformatf("%s_end_tx", tag),   {31'b0, bus.tx},   32'd1);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_idle_tx", tag),   {31'b0, bus.tx},   32'd1);
      check($sformatf("%s_idle_busy", tag), {31'b0, bus.busy}, 32'd0);
      check($sformatf("%s_idle_done", tag), {31'b0, bus.done}, 32'd0);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    bus.baud_tick   = 1'b0;
    bus.send        = 1'b0;
    bus.data_in     = 8'h00;
    bus.parity_type = 2'b00;
`ifdef UART_TX_BREAK_EN
    bus.break_req   = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("rst_tx",   {31'b0, bus.tx},   32'd1);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    reset_n = 1'b1;
    idle_ticks("post_rst", 1);

    // Accept with a coincident tick: start bit must wait for the next tick.
    accept(8'hA5, 2'b10, 1'b1);
    run_frame("a5_even", 11'b01010010101, -1);
    idle_ticks("a5_even", 2);

    accept(8'h00, 2'b01, 1'b0);
    run_frame("00_odd", 11'b00000000011, -1);
    idle_ticks("00_odd", 1);

    accept(8'h01, 2'b01, 1'b0);
    run_frame("01_odd", 11'b01000000001, -1);
    idle_ticks("01_odd", 1);

    accept(8'h3C, 2'b00, 1'b0);
    run_frame("3c_none00", 11'b00011110011, -1);
    idle_ticks("3c_none00", 1);

    accept(8'h3C, 2'b11, 1'b0);
    run_frame("3c_none11", 11'b00011110011, -1);
    idle_ticks("3c_none11", 1);

    // send 0xFF mid-frame must be dropped.
    accept(8'hA5, 2'b10, 1'b0);
    run_frame("a5_inject", 11'b01010010101, 4);
    idle_ticks("a5_inject", 2);

    // Back-to-back: second send lands in the done cycle.
    accept(8'hA5, 2'b10, 1'b0);
    run_frame("b2b_first", 11'b01010010101, -1);
    accept(8'h5A, 2'b10, 1'b0);
    run_frame("b2b_second", 11'b00101101001, -1);
    idle_ticks("b2b", 1);

    // Async reset while a data bit 0 is on the line.
    accept(8'hA5, 2'b10, 1'b0);
    tick();
    tick();
    tick();
    check("mid_pre_tx", {31'b0, bus.tx}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tx",   {31'b0, bus.tx},   32'd1);
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'b0, bus.done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_ticks("mid_rst", 2);

`ifdef UART_TX_BREAK_EN
    bus.break_req = 1'b1;
    @(negedge clock);
    check("brk_idle_tx", {31'b0, bus.tx}, 32'd0);
    bus.send    = 1'b1;
    bus.data_in = 8'h55;
    @(negedge clock);
    bus.send    = 1'b0;
    check("brk_send_busy", {31'b0, bus.busy}, 32'd0);
    check("brk_send_tx",   {31'b0, bus.tx},   32'd0);
    bus.break_req = 1'b0;
    @(negedge clock);
    check("brk_release_tx", {31'b0, bus.tx}, 32'd1);
    idle_ticks("brk_release", 1);

    accept(8'h5A, 2'b10, 1'b0);
    bus.break_req = 1'b1;
    run_frame("brk_frame", 11'b00101101001, -1);
    @(negedge clock);
    check("brk_after_tx",   {31'b0, bus.tx},   32'd0);
    check("brk_after_busy", {31'b0, bus.busy}, 32'd0);
    bus.break_req = 1'b0;
    @(negedge clock);
    check("brk_after_release_tx", {31'b0, bus.tx}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
